synth_nco_clk_gen: RTL and testbench
====================================

# synth_nco_clk_gen

Single-clock, phase-accumulator (NCO) timing generator for the synth engine. It produces the audio serial bit clock, the LR frame clock and a frame strobe. It also issues a fixed number of per-frame envelope/oscillator slot strobes with slot indices. All outputs are registered in the `OSC_CLK` domain, and fractional frequency words give exact sample rates. New frequency words are adopted phase-continuously at frame boundaries only.

## Interface
- `ACC_W`, 32, phase-accumulator width.
- `DATA_WIDTH`, 16, bits per channel slot.
- `CHANNEL_NUM`, 2, channels per frame.
- `VOICES`, 8, voices; power of two.
- `V_OSC`, 4, oscillators per voice; power of two.
- `V_ENVS`, 8, envelopes per voice; power of two, multiple of `V_OSC`.
- `DEF_AUD_FW`, 32'h8000_0000, audio frequency word after reset.
- `DEF_ENG_FW`, 32'hC000_0000, engine frequency word after reset.
- `OSC_CLK`  in  1  sole clock; all logic rising-edge.
- `iRST_N`  in  1  asynchronous, active-low reset.
- `iAUD_FW`  in  ACC_W  requested audio frequency word; sampled at frame boundary.
- `iENG_FW`  in  ACC_W  requested engine frequency word; sampled at frame boundary.
- `oAUD_BCK`  out  1  bit clock (registered level).
- `LRCK_1X`  out  1  frame clock: 0 = left/channel 0 half, 1 = remaining channels.
- `oFRAME_STB`  out  1  1-cycle pulse at frame start.
- `oENV_STB`  out  1  1-cycle envelope-slot pulse.
- `oOSC_STB`  out  1  1-cycle oscillator-slot pulse, coincident with a subset of `oENV_STB`.
- `oVOICE_IDX`  out  clog2(VOICES)  voice of current slot.
- `oENV_IDX`  out  clog2(V_ENVS)  envelope index of current slot.
- `oOSC_IDX`  out  clog2(V_OSC)  oscillator index, valid with `oOSC_STB`.
- `oUNDERRUN`  out  1  sticky flag: a frame ended before all slots were issued.

## Operation
- Audio NCO: each cycle, `{acarry, aacc} <= aacc + aud_fw_act` (ACC_W+1-bit sum, wrap modulo 2^ACC_W). The edge that writes `acarry`=1 toggles `oAUD_BCK`.
- `bitcnt` (0..DATA_WIDTH*CHANNEL_NUM-1) advances on each BCK 1→0 toggle and wraps to 0.
- On the same edge, `LRCK_1X <= 0` when bitcnt becomes 0. `LRCK_1X <= 1` when it becomes DATA_WIDTH.
- Frame boundary is the edge where bitcnt wraps to 0. On that edge:
  - `oFRAME_STB` pulses.
  - `aud_fw_act <= iAUD_FW` and `eng_fw_act <= iENG_FW`, used from the next addition.
  - Accumulators are not cleared.
- Engine NCO: identical adder on `eng_fw_act`. On carry, if `slot < VOICES*V_ENVS`:
  - `oENV_STB` pulses, with `oVOICE_IDX = slot / V_ENVS` and `oENV_IDX = slot % V_ENVS`.
  - `oOSC_STB` also pulses when `slot % (V_ENVS/V_OSC) == 0`, with `oOSC_IDX = (slot % V_ENVS) / (V_ENVS/V_OSC)`.
  - `slot++`.
- Engine carries with `slot` exhausted are suppressed.
- At a frame boundary:
  - If `slot < VOICES*V_ENVS`, `oUNDERRUN <= 1`; it is cleared only by reset.
  - `slot <= 0`.
  - A simultaneous engine carry is issued as slot 0, then `slot <= 1`.
- Frequency word 0 produces no carries; outputs hold.

## Timing
- Reset values:
  - Accumulators 0, `bitcnt` 0, `slot` 0.
  - `oAUD_BCK` 0, `LRCK_1X` 0.
  - All strobes 0, all indices 0, `oUNDERRUN` 0.
  - Active words = `DEF_*`.
- Reset mid-operation restarts all of the above immediately (asynchronously). The first frame boundary after reset occurs after DATA_WIDTH*CHANNEL_NUM BCK periods.
- Latency:
  - A carry appears on outputs at the clock edge that computes it.
  - Strobes and indices are registered together and valid for exactly that one cycle.
- Rates:
  - BCK = F_clk·aud_fw/2^(ACC_W+1).
  - fs = BCK/(DATA_WIDTH·CHANNEL_NUM).
  - Engine slot rate = F_clk·eng_fw/2^ACC_W, which must be ≥ fs·VOICES·V_ENVS.
- A word change mid-frame has no effect until the next frame boundary, so there are no partial-frame rate changes.

## Structure
- A shared package `synth_clk_pkg` holds:
  - the default frequency words;
  - the slot-count function `VOICES*V_ENVS`;
  - `clog2`-derived index widths.
- One sub-module, `synth_nco_acc` (ACC_W adder + carry register + active-word register with load strobe), is instantiated twice.

## Test plan
- Reset defaults (ACC_W=32, DW=16, CH=2): BCK toggles every 2 cycles; frame = 128 cycles; `LRCK_1X` high for cycles 64–127 of each frame; `oFRAME_STB` every 128 cycles.
- Engine default 0xC000_0000: 96 carries per frame → exactly 64 `oENV_STB`, 32 `oOSC_STB`; `oVOICE_IDX` 0..7 in order; `oOSC_IDX` 0..3 per voice; `oUNDERRUN` stays 0.
- `iENG_FW`=0x4000_0000 applied mid-frame → unchanged until next boundary; following frame issues 32 slots → `oUNDERRUN`=1 at that frame's end and stays set.
- `iAUD_FW` changed from 0x8000_0000 to 0x4000_0000 mid-frame → current frame stays 128 cycles; next frame is 256 cycles; `LRCK_1X` never glitches.
- `iAUD_FW`=0 and `iENG_FW`=0 at boundary → all outputs frozen, no strobes for 1000 cycles.
- Assert `iRST_N` low mid-frame → all outputs 0 within the same cycle; after release, the first `oFRAME_STB` occurs at cycle 128.

Source files
------------

// File: rtl/synth_clk_pkg.sv
// Shared constants and sizing helpers for the synth NCO timing generator.
package synth_clk_pkg;

    localparam logic [31:0] DefAudFw = 32'h8000_0000;
    localparam logic [31:0] DefEngFw = 32'hC000_0000;

    function automatic int unsigned num_slots(input int unsigned voices, input int unsigned envs);
        return voices * envs;
    endfunction

    // Index width that never collapses to zero bits.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/synth_nco_acc.sv
// Phase accumulator with an active frequency word that is only replaced on ld_i.
// carry_o is the carry of the sum being registered on the coming edge.
module synth_nco_acc
    import synth_clk_pkg::*;
#(
    parameter int unsigned      ACC_W  = 32,
    parameter logic [ACC_W-1:0] DEF_FW = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             ld_i,
    input  logic [ACC_W-1:0] fw_i,
    output logic             carry_o
);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] fw_q, fw_d;

    always_comb begin
        {carry_o, acc_d} = {1'b0, acc_q} + {1'b0, fw_q};
        // A word loaded this edge is used from the next addition onward.
        fw_d = ld_i ? fw_i : fw_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q <= '0;
            fw_q  <= DEF_FW;
        end else begin
            acc_q <= acc_d;
            fw_q  <= fw_d;
        end
    end

endmodule

// File: rtl/synth_nco_clk_gen.sv
// NCO-based audio bit/frame clock generator with per-frame envelope/oscillator slot strobes.
// New frequency words are adopted at frame boundaries only.
module synth_nco_clk_gen
    import synth_clk_pkg::*;
#(
    parameter int unsigned      ACC_W       = 32,
    parameter int unsigned      DATA_WIDTH  = 16,
    parameter int unsigned      CHANNEL_NUM = 2,
    parameter int unsigned      VOICES      = 8,
    parameter int unsigned      V_OSC       = 4,
    parameter int unsigned      V_ENVS      = 8,
    parameter logic [ACC_W-1:0] DEF_AUD_FW  = ACC_W'(DefAudFw),
    parameter logic [ACC_W-1:0] DEF_ENG_FW  = ACC_W'(DefEngFw)
) (
    input  logic                     OSC_CLK,
    input  logic                     iRST_N,
    input  logic [ACC_W-1:0]         iAUD_FW,
    input  logic [ACC_W-1:0]         iENG_FW,
    output logic                     oAUD_BCK,
    output logic                     LRCK_1X,
    output logic                     oFRAME_STB,
    output logic                     oENV_STB,
    output logic                     oOSC_STB,
    output logic [idx_w(VOICES)-1:0] oVOICE_IDX,
    output logic [idx_w(V_ENVS)-1:0] oENV_IDX,
    output logic [idx_w(V_OSC)-1:0]  oOSC_IDX,
    output logic                     oUNDERRUN
);

    localparam int unsigned VoiceW    = idx_w(VOICES);
    localparam int unsigned EnvW      = idx_w(V_ENVS);
    localparam int unsigned OscW      = idx_w(V_OSC);
    localparam int unsigned NumSlots  = num_slots(VOICES, V_ENVS);
    localparam int unsigned SlotW     = EnvW + VoiceW + 1;
    localparam int unsigned EpoLog    = $clog2(V_ENVS / V_OSC);
    localparam int unsigned FrameBits = DATA_WIDTH * CHANNEL_NUM;
    localparam int unsigned BitW      = idx_w(FrameBits);

    localparam logic [SlotW-1:0] SlotMax  = SlotW'(NumSlots);
    localparam logic [EnvW-1:0]  EnvMask  = EnvW'(V_ENVS / V_OSC - 1);
    localparam logic [BitW-1:0]  BitLast  = BitW'(FrameBits - 1);
    localparam logic [BitW-1:0]  BitHalfM = BitW'(DATA_WIDTH - 1);

    logic a_carry, e_carry;
    logic bck_fall, frame_end, issue, osc_hit;

    logic              bck_q, bck_d;
    logic              lrck_q, lrck_d;
    logic [BitW-1:0]   bitcnt_q, bitcnt_d;
    logic [SlotW-1:0]  slot_q, slot_d, slot_eff;
    logic [EnvW-1:0]   env_sel;
    logic              frame_stb_q, env_stb_q, osc_stb_q;
    logic [VoiceW-1:0] voice_q, voice_d;
    logic [EnvW-1:0]   env_idx_q, env_idx_d;
    logic [OscW-1:0]   osc_idx_q, osc_idx_d;
    logic              underrun_q, underrun_d;

    synth_nco_acc #(
        .ACC_W  (ACC_W),
        .DEF_FW (DEF_AUD_FW)
    ) u_aud_acc (
        .clk_i   (OSC_CLK),
        .rst_ni  (iRST_N),
        .ld_i    (frame_end),
        .fw_i    (iAUD_FW),
        .carry_o (a_carry)
    );

    synth_nco_acc #(
        .ACC_W  (ACC_W),
        .DEF_FW (DEF_ENG_FW)
    ) u_eng_acc (
        .clk_i   (OSC_CLK),
        .rst_ni  (iRST_N),
        .ld_i    (frame_end),
        .fw_i    (iENG_FW),
        .carry_o (e_carry)
    );

    always_comb begin
        bck_fall  = a_carry & bck_q;
        frame_end = bck_fall & (bitcnt_q == BitLast);
        bck_d     = bck_q ^ a_carry;

        bitcnt_d = bitcnt_q;
        lrck_d   = lrck_q;
        if (bck_fall) begin
            bitcnt_d = frame_end ? '0 : bitcnt_q + BitW'(1);
            if (frame_end) begin
                lrck_d = 1'b0;
            end else if (bitcnt_q == BitHalfM) begin
                lrck_d = 1'b1;
            end
        end

        // A boundary restarts slot numbering; a coincident engine carry becomes slot 0.
        slot_eff   = frame_end ? '0 : slot_q;
        underrun_d = underrun_q | (frame_end & (slot_q < SlotMax));
        issue      = e_carry & (slot_eff < SlotMax);
        slot_d     = issue ? slot_eff + SlotW'(1) : slot_eff;

        env_sel   = slot_eff[EnvW-1:0];
        osc_hit   = (env_sel & EnvMask) == '0;
        voice_d   = issue ? slot_eff[EnvW +: VoiceW] : voice_q;
        env_idx_d = issue ? env_sel : env_idx_q;
        osc_idx_d = (issue && osc_hit) ? OscW'(env_sel >> EpoLog) : osc_idx_q;
    end

    always_ff @(posedge OSC_CLK or negedge iRST_N) begin
        if (!iRST_N) begin
            bck_q       <= 1'b0;
            lrck_q      <= 1'b0;
            bitcnt_q    <= '0;
            slot_q      <= '0;
            frame_stb_q <= 1'b0;
            env_stb_q   <= 1'b0;
            osc_stb_q   <= 1'b0;
            voice_q     <= '0;
            env_idx_q   <= '0;
            osc_idx_q   <= '0;
            underrun_q  <= 1'b0;
        end else begin
            bck_q       <= bck_d;
            lrck_q      <= lrck_d;
            bitcnt_q    <= bitcnt_d;
            slot_q      <= slot_d;
            frame_stb_q <= frame_end;
            env_stb_q   <= issue;
            osc_stb_q   <= issue & osc_hit;
            voice_q     <= voice_d;
            env_idx_q   <= env_idx_d;
            osc_idx_q   <= osc_idx_d;
            underrun_q  <= underrun_d;
        end
    end

    assign oAUD_BCK   = bck_q;
    assign LRCK_1X    = lrck_q;
    assign oFRAME_STB = frame_stb_q;
    assign oENV_STB   = env_stb_q;
    assign oOSC_STB   = osc_stb_q;
    assign oVOICE_IDX = voice_q;
    assign oENV_IDX   = env_idx_q;
    assign oOSC_IDX   = osc_idx_q;
    assign oUNDERRUN  = underrun_q;

endmodule

// File: tb/tb_synth_nco_clk_gen.sv
// Directed bench for synth_nco_clk_gen at default parameters.
module tb_synth_nco_clk_gen;

    logic        OSC_CLK = 1'b0;
    logic        iRST_N  = 1'b1;
    logic [31:0] iAUD_FW = 32'h8000_0000;
    logic [31:0] iENG_FW = 32'hC000_0000;
    logic        oAUD_BCK, LRCK_1X, oFRAME_STB, oENV_STB, oOSC_STB, oUNDERRUN;
    logic [2:0]  oVOICE_IDX, oENV_IDX;
    logic [1:0]  oOSC_IDX;

    synth_nco_clk_gen dut (
        .OSC_CLK    (OSC_CLK),
        .iRST_N     (iRST_N),
        .iAUD_FW    (iAUD_FW),
        .iENG_FW    (iENG_FW),
        .oAUD_BCK   (oAUD_BCK),
        .LRCK_1X    (LRCK_1X),
        .oFRAME_STB (oFRAME_STB),
        .oENV_STB   (oENV_STB),
        .oOSC_STB   (oOSC_STB),
        .oVOICE_IDX (oVOICE_IDX),
        .oENV_IDX   (oENV_IDX),
        .oOSC_IDX   (oOSC_IDX),
        .oUNDERRUN  (oUNDERRUN)
    );

    always #5 OSC_CLK = ~OSC_CLK;

    int n_tests = 0;
    int n_fail  = 0;

    // Per-frame counters, snapshotted into last_* on each frame strobe.
    int cyc, env_cnt, osc_cnt, idx_err, lr_rise, lr_chg, bck_tog;
    int last_len, last_env, last_osc, last_idx_err, last_lr_rise, last_lr_chg, last_bck;
    int tot_env, tot_osc, tot_frames, tot_bck, tot_lr;
    logic bck_prev, lr_prev;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_counters();
        cyc = 0; env_cnt = 0; osc_cnt = 0; idx_err = 0;
        lr_rise = 0; lr_chg = 0; bck_tog = 0;
        bck_prev = oAUD_BCK;
        lr_prev  = LRCK_1X;
    endtask

    task automatic tick();
        int k;
        @(posedge OSC_CLK);
        #1;
        cyc++;
        if (oAUD_BCK != bck_prev) begin
            bck_tog++;
            tot_bck++;
        end
        if (LRCK_1X != lr_prev) tot_lr++;
        if (oFRAME_STB) begin
            tot_frames++;
            last_len = cyc; last_env = env_cnt; last_osc = osc_cnt; last_idx_err = idx_err;
            last_lr_rise = lr_rise; last_lr_chg = lr_chg; last_bck = bck_tog;
            cyc = 0; env_cnt = 0; osc_cnt = 0; idx_err = 0;
            lr_rise = 0; lr_chg = 0; bck_tog = 0;
        end else if (LRCK_1X != lr_prev) begin
            lr_chg++;
            if (LRCK_1X) lr_rise = cyc;
        end
        k = env_cnt;
        if (oENV_STB) begin
            if (oVOICE_IDX != 3'(k / 8) || oENV_IDX != 3'(k % 8)) idx_err++;
            if ((k % 2 == 0) && !oOSC_STB) idx_err++;
            env_cnt++;
            tot_env++;
        end
        if (oOSC_STB) begin
            if (!oENV_STB || (k % 2 != 0) || oOSC_IDX != 2'((k % 8) / 2)) idx_err++;
            osc_cnt++;
            tot_osc++;
        end
        bck_prev = oAUD_BCK;
        lr_prev  = LRCK_1X;
    endtask

    task automatic run_until_frame(input int max_cyc);
        int got;
        got = 0;
        for (int i = 0; i < max_cyc && got == 0; i++) begin
            tick();
            if (oFRAME_STB) got = 1;
        end
        check_eq("frame_seen", got, 1);
    endtask

    task automatic check_outputs_zero();
        check_eq("rst_bck", int'(oAUD_BCK), 0);
        check_eq("rst_lrck", int'(LRCK_1X), 0);
        check_eq("rst_frame_stb", int'(oFRAME_STB), 0);
        check_eq("rst_env_stb", int'(oENV_STB), 0);
        check_eq("rst_osc_stb", int'(oOSC_STB), 0);
        check_eq("rst_voice_idx", int'(oVOICE_IDX), 0);
        check_eq("rst_env_idx", int'(oENV_IDX), 0);
        check_eq("rst_osc_idx", int'(oOSC_IDX), 0);
        check_eq("rst_underrun", int'(oUNDERRUN), 0);
    endtask

    task automatic check_default_frame();
        check_eq("def_len", last_len, 128);
        check_eq("def_env", last_env, 64);
        check_eq("def_osc", last_osc, 32);
        check_eq("def_idx_order", last_idx_err, 0);
        check_eq("def_lr_rise", last_lr_rise, 64);
        check_eq("def_lr_chg", last_lr_chg, 1);
        check_eq("def_bck_tog", last_bck, 64);
        check_eq("def_lrck_at_stb", int'(LRCK_1X), 0);
    endtask

    initial begin
        int e0, o0, f0, b0, l0;
        tot_env = 0; tot_osc = 0; tot_frames = 0; tot_bck = 0; tot_lr = 0;

        #3 iRST_N = 1'b0;
        #4 check_outputs_zero();
        repeat (3) @(posedge OSC_CLK);
        #1 iRST_N = 1'b1;
        clear_counters();

        // First frame after reset and one steady-state frame at default words.
        run_until_frame(200);
        check_default_frame();
        check_eq("f1_underrun", int'(oUNDERRUN), 0);
        run_until_frame(200);
        check_default_frame();

        // Slow engine word requested mid-frame: current frame unaffected.
        repeat (40) tick();
        iENG_FW = 32'h4000_0000;
        run_until_frame(200);
        check_eq("eng_chg_cur_env", last_env, 64);
        check_eq("eng_chg_cur_len", last_len, 128);
        check_eq("eng_chg_no_underrun", int'(oUNDERRUN), 0);
        run_until_frame(200);
        check_eq("slow_eng_env", last_env, 32);
        check_eq("slow_eng_osc", last_osc, 16);
        check_eq("slow_eng_idx_order", last_idx_err, 0);
        check_eq("underrun_set", int'(oUNDERRUN), 1);

        // Restore engine, halve audio word mid-frame.
        repeat (50) tick();
        iENG_FW = 32'hC000_0000;
        iAUD_FW = 32'h4000_0000;
        run_until_frame(200);
        check_eq("aud_chg_cur_len", last_len, 128);
        check_eq("aud_chg_cur_env", last_env, 32);
        check_eq("underrun_sticky", int'(oUNDERRUN), 1);
        run_until_frame(400);
        check_eq("slow_aud_len", last_len, 256);
        check_eq("slow_aud_env", last_env, 64);
        check_eq("slow_aud_osc", last_osc, 32);
        check_eq("slow_aud_idx_order", last_idx_err, 0);
        check_eq("slow_aud_lr_rise", last_lr_rise, 128);
        check_eq("slow_aud_lr_chg", last_lr_chg, 1);
        check_eq("slow_aud_bck_tog", last_bck, 64);
        check_eq("underrun_sticky2", int'(oUNDERRUN), 1);

        // Asynchronous reset mid-frame while LRCK is high.
        repeat (150) tick();
        check_eq("pre_rst_lrck", int'(LRCK_1X), 1);
        iAUD_FW = 32'h8000_0000;
        #2 iRST_N = 1'b0;
        #1 check_outputs_zero();
        repeat (2) @(posedge OSC_CLK);
        #1 iRST_N = 1'b1;
        clear_counters();
        run_until_frame(200);
        check_default_frame();
        check_eq("post_rst_underrun", int'(oUNDERRUN), 0);

        // Zero words adopted at a boundary freeze everything.
        repeat (30) tick();
        iAUD_FW = 32'h0;
        iENG_FW = 32'h0;
        run_until_frame(200);
        check_eq("pre_freeze_len", last_len, 128);
        e0 = tot_env; o0 = tot_osc; f0 = tot_frames; b0 = tot_bck; l0 = tot_lr;
        repeat (1000) tick();
        check_eq("freeze_env", tot_env - e0, 0);
        check_eq("freeze_osc", tot_osc - o0, 0);
        check_eq("freeze_frames", tot_frames - f0, 0);
        check_eq("freeze_bck", tot_bck - b0, 0);
        check_eq("freeze_lrck", tot_lr - l0, 0);
        check_eq("freeze_bck_lvl", int'(oAUD_BCK), 0);
        check_eq("freeze_underrun", int'(oUNDERRUN), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
